// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply hold and
// taken-branch flush, with saturating stall/flush event counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | normal issue; resolves load-use, branch flush, mul start
//   MUL_WAIT | multiply occupying EX; ID/EX frozen, front end stalled
module hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ifid_rs1_i,
   input  logic [4:0]  ifid_rs2_i,
   input  logic [4:0]  idex_rd_i,
   input  logic        idex_MemRead_i,
   input  logic        idex_Mul_i,
   input  logic        branch_taken_i,
   output logic        PCWrite_o,
   output logic        IFIDWrite_o,
   output logic        NoOp_o,
   output logic        Flush_o,
   output logic        ExHold_o,
   output logic [15:0] stall_cycles_o,
   output logic [7:0]  flush_count_o
);

   typedef enum logic {IDLE, MUL_WAIT} state_t;

   // cnt holds the number of MUL_WAIT cycles still to go, including the current one
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mul_seen_q, mul_seen_d;
   logic [15:0] stall_q, stall_d;
   logic [7:0]  flush_q, flush_d;
   logic        lu, mt;

   always_comb begin
      lu = idex_MemRead_i && (idex_rd_i != 5'd0) &&
           ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
      mt = (state_q == IDLE) && idex_Mul_i && !mul_seen_q;

      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_seen_d  = mul_seen_q;
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      NoOp_o      = 1'b0;
      Flush_o     = 1'b0;
      ExHold_o    = 1'b0;

      case (state_q)
         IDLE: begin
            if (mt) begin
               ExHold_o    = 1'b1;
               PCWrite_o   = 1'b0;
               IFIDWrite_o = 1'b0;
               // at the minimum latency the trigger cycle alone covers the hold
               if (CNT_LOAD == 4'd0) begin
                  mul_seen_d = 1'b1;
               end else begin
                  state_d = MUL_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end else begin
               mul_seen_d = 1'b0;
               if (lu) begin
                  NoOp_o      = 1'b1;
                  PCWrite_o   = 1'b0;
                  IFIDWrite_o = 1'b0;
               end else if (branch_taken_i) begin
                  Flush_o = 1'b1;
               end
            end
         end
         MUL_WAIT: begin
            ExHold_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            cnt_d       = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
               state_d    = IDLE;
               mul_seen_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!rst_i) begin
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         NoOp_o      = 1'b1;
         Flush_o     = 1'b0;
         ExHold_o    = 1'b0;
      end

      stall_d = stall_q;
      if (!PCWrite_o && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
      flush_d = flush_q;
      if (Flush_o && (flush_q != 8'hFF)) flush_d = flush_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         mul_seen_q <= 1'b0;
         stall_q    <= 16'd0;
         flush_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mul_seen_q <= mul_seen_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
      end
   end

   assign stall_cycles_o = stall_q;
   assign flush_count_o  = flush_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, meaning EX-stage multiply latency in cycles; legal range 2..16.
REQ-002 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-low.
REQ-004 ifid_rs1_i  input  5  rs1 field of the instruction in IF/ID.
REQ-005 ifid_rs2_i  input  5  rs2 field of the instruction in IF/ID.
REQ-006 idex_rd_i  input  5  rd of the instruction in ID/EX.
REQ-007 idex_MemRead_i  input  1  instruction in ID/EX is a load.
REQ-008 idex_Mul_i  input  1  instruction in ID/EX is a multiply; stays high while ID/EX is held.
REQ-009 branch_taken_i  input  1  branch resolved taken in ID this cycle.
REQ-010 PCWrite_o  output  1  PC update enable.
REQ-011 IFIDWrite_o  output  1  IF/ID load enable.
REQ-012 NoOp_o  output  1  zero ID/EX control fields on next edge; drives ID/EX NoOp_i.
REQ-013 Flush_o  output  1  replace IF/ID contents with a bubble on next edge.
REQ-014 ExHold_o  output  1  freeze ID/EX; bubble into EX/MEM.
REQ-015 stall_cycles_o  output  16  saturating count of cycles with PCWrite_o low.
REQ-016 flush_count_o  output  8  saturating count of cycles with Flush_o high.

Function
REQ-017 FSM states SHALL be IDLE and MUL_WAIT; a 4-bit down-counter cnt and a 1-bit mul_seen flag SHALL be registered.
REQ-018 Outputs SHALL be combinational from registered state plus current inputs (same-cycle response, zero latency).
REQ-019 Load-use hazard lu = idex_MemRead_i & (idex_rd_i != 0) & (idex_rd_i == ifid_rs1_i | idex_rd_i == ifid_rs2_i).
REQ-020 Mul trigger mt = idex_Mul_i & ~mul_seen, evaluated only in IDLE.
REQ-021 IDLE, mt: ExHold_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0; next state MUL_WAIT, cnt <= MUL_LAT-2.
REQ-022 MUL_WAIT: same outputs as REQ-021; cnt decrements each cycle; when cnt==0 next state IDLE and mul_seen <= 1.
REQ-023 Total ExHold_o assertion per multiply SHALL equal MUL_LAT-1 consecutive cycles.
REQ-024 mul_seen SHALL clear on the edge after the first IDLE cycle following MUL_WAIT, so a held idex_Mul_i never retriggers.
REQ-025 IDLE, ~mt, lu: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0, ExHold_o=0; state stays IDLE (one-cycle stall; bubble clears lu).
REQ-026 IDLE, ~mt, ~lu, branch_taken_i: Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0.
REQ-027 IDLE, no condition: PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0, Flush_o=0, ExHold_o=0.
REQ-028 Priority SHALL be mt > lu > branch_taken_i; branch_taken_i SHALL be ignored during MUL_WAIT and during lu.
REQ-029 idex_MemRead_i and idex_Mul_i both high SHALL be treated as multiply.
REQ-030 stall_cycles_o SHALL increment by 1 on each edge with rst_i=1 and PCWrite_o=0, holding at 16'hFFFF.
REQ-031 flush_count_o SHALL increment by 1 on each edge with rst_i=1 and Flush_o=1, holding at 8'hFF.

Reset
REQ-032 rst_i=0 at an edge SHALL set state IDLE, cnt=0, mul_seen=0, stall_cycles_o=0, flush_count_o=0.
REQ-033 While rst_i=0: PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0, ExHold_o=0, regardless of other inputs.
REQ-034 Reset asserted during MUL_WAIT SHALL abort the wait; first cycle after release is IDLE with mul_seen=0.

Verification
REQ-035 Load-use: idex_MemRead_i=1, idex_rd_i=5, ifid_rs2_i=5 for 1 cycle -> NoOp_o=1, PCWrite_o=0 that cycle only; stall_cycles_o 0->1.
REQ-036 rd=x0: idex_MemRead_i=1, idex_rd_i=0, ifid_rs1_i=0 -> no stall, PCWrite_o=1, NoOp_o=0.
REQ-037 Multiply, MUL_LAT=4: idex_Mul_i held high 4 cycles -> ExHold_o high exactly 3 cycles, low on 4th, no retrigger; stall_cycles_o=3.
REQ-038 Priority: lu and branch_taken_i same cycle -> Flush_o=0, NoOp_o=1; next cycle branch_taken_i alone -> Flush_o=1, flush_count_o=1.
REQ-039 Reset mid-multiply: rst_i=0 in 2nd MUL_WAIT cycle -> outputs per REQ-033, counters 0; after release with idex_Mul_i=1, new 3-cycle hold.
REQ-040 Saturation: 70000 forced stall cycles -> stall_cycles_o=16'hFFFF, no wrap.
